// File: rtl/keypad_pkg.sv
// Shared types and key codes for the keypad UART receiver and keyboard_driver.
// KEYPAD_FILTER_EN (in uart_keypad_rx) restricts commits to the KEY_MIN..KEY_MAX range.
package keypad_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } rx_state_e;

    localparam logic [7:0] KEY_1 = 8'h31;
    localparam logic [7:0] KEY_2 = 8'h32;
    localparam logic [7:0] KEY_3 = 8'h33;
    localparam logic [7:0] KEY_4 = 8'h34;
    localparam logic [7:0] KEY_5 = 8'h35;
    localparam logic [7:0] KEY_6 = 8'h36;
    localparam logic [7:0] KEY_7 = 8'h37;
    localparam logic [7:0] KEY_8 = 8'h38;
    localparam logic [7:0] KEY_9 = 8'h39;

    localparam logic [7:0] KEY_MIN = KEY_1;
    localparam logic [7:0] KEY_MAX = KEY_9;

    function automatic logic is_key(input logic [7:0] b);
        return (b >= KEY_MIN) && (b <= KEY_MAX);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for asynchronous inputs; both flops reset to 1 (idle line level).
module rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_keypad_rx.sv
// 8N1 UART receiver holding the last accepted byte on word_out for keyboard_driver.
// Define KEYPAD_FILTER_EN to commit only ASCII '1'..'9'.
module uart_keypad_rx
    import keypad_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] word_out,
    output logic       word_valid,
    output logic       frame_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    rx_state_e     state, next_state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_s;
    logic          sample, shift_en, commit, ferr_set, accept;

    rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst),
        .d     (rx),
        .q     (rx_s)
    );

`ifdef KEYPAD_FILTER_EN
    assign accept = is_key(shreg);
`else
    assign accept = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:      if (!rx_s) next_state = S_START;
            S_START:     if (sample) next_state = rx_s ? S_IDLE : S_DATA;
            S_DATA:      if (sample && bit_idx == 3'd7) next_state = S_STOP;
            S_STOP:      if (sample) next_state = rx_s ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (rx_s) next_state = S_IDLE;
            default:     next_state = S_IDLE;
        endcase
    end

    // Start is sampled at mid-bit so every later full-period sample lands mid-bit too.
    always_comb begin
        sample   = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        ferr_set = 1'b0;
        case (state)
            S_START: sample = (baud_cnt == HALF_M1);
            S_DATA: begin
                sample   = (baud_cnt == FULL_M1);
                shift_en = sample;
            end
            S_STOP: begin
                sample   = (baud_cnt == FULL_M1);
                commit   = sample && rx_s && accept;
                ferr_set = sample && !rx_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
        end else begin
            if ((state == S_START || state == S_DATA || state == S_STOP) && !sample)
                baud_cnt <= baud_cnt + 1'b1;
            else
                baud_cnt <= '0;
            if (shift_en) begin
                shreg   <= {rx_s, shreg[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // word_out only loads on commit, so shift-register contents never leak downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_out   <= 8'h00;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            word_valid <= commit;
            frame_err  <= ferr_set;
            if (commit) word_out <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_keypad_rx.sv
// Directed bench for uart_keypad_rx at 10 clocks per bit; expectations track KEYPAD_FILTER_EN.
module tb_uart_keypad_rx;

    localparam int N = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] word_out;
    logic       word_valid;
    logic       frame_err;

    always #5 clk = ~clk;

    uart_keypad_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .word_out   (word_out),
        .word_valid (word_valid),
        .frame_err  (frame_err)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0, vcnt = 0, fcnt = 0, both_cnt = 0, wide_cnt = 0;
    int t_prev = 0, t_last = 0;
    logic wv_q = 1'b0, fe_q = 1'b0;

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (word_valid) begin
            vcnt   <= vcnt + 1;
            t_prev <= t_last;
            t_last <= cyc;
        end
        if (frame_err) fcnt <= fcnt + 1;
        if (word_valid && frame_err) both_cnt <= both_cnt + 1;
        if ((word_valid && wv_q) || (frame_err && fe_q)) wide_cnt <= wide_cnt + 1;
        wv_q <= word_valid;
        fe_q <= frame_err;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (N) @(negedge clk);
        end
        rx = stop;
        repeat (N) @(negedge clk);
    endtask

    int v0, f0;

    initial begin
        // reset state
        idle(3);
        check("rst_word", word_out, 8'h00);
        check("rst_valid", word_valid, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        idle(5);

        // 1: single '8'
        v0 = vcnt; f0 = fcnt;
        send(8'h38, 1'b1);
        idle(5);
        check("t1_pulses", vcnt - v0, 1);
        check("t1_word", word_out, 8'h38);
        check("t1_ferr", fcnt - f0, 0);

        // 2: back-to-back '4','6'
        v0 = vcnt;
        send(8'h34, 1'b1);
        send(8'h36, 1'b1);
        idle(5);
        check("t2_pulses", vcnt - v0, 2);
        check("t2_spacing", t_last - t_prev, 100);
        check("t2_word", word_out, 8'h36);

        // 3: short glitch
        v0 = vcnt; f0 = fcnt;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        idle(30);
        check("t3_pulses", vcnt - v0, 0);
        check("t3_ferr", fcnt - f0, 0);
        check("t3_word", word_out, 8'h36);

        // 4: bad stop bit, line held low, then recovery
        v0 = vcnt; f0 = fcnt;
        send(8'h32, 1'b0);
        repeat (30) @(negedge clk);
        rx = 1'b1;
        idle(5);
        check("t4_ferr", fcnt - f0, 1);
        check("t4_pulses", vcnt - v0, 0);
        check("t4_word", word_out, 8'h36);
        v0 = vcnt;
        send(8'h35, 1'b1);
        idle(5);
        check("t4_rec_pulses", vcnt - v0, 1);
        check("t4_rec_word", word_out, 8'h35);

        // 5: non-key byte then '9'
        v0 = vcnt;
        send(8'h41, 1'b1);
        idle(5);
`ifdef KEYPAD_FILTER_EN
        check("t5_a_pulses", vcnt - v0, 0);
        check("t5_a_word", word_out, 8'h35);
`else
        check("t5_a_pulses", vcnt - v0, 1);
        check("t5_a_word", word_out, 8'h41);
`endif
        v0 = vcnt;
        send(8'h39, 1'b1);
        idle(5);
        check("t5_b_pulses", vcnt - v0, 1);
        check("t5_b_word", word_out, 8'h39);

        // 6: reset during data bit 4 of 8'hF0 (bits 4..7 high, so the tail looks idle)
        v0 = vcnt; f0 = fcnt;
        rx = 1'b0;
        repeat (5 * N) @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rst_word", word_out, 8'h00);
        check("t6_rst_valid", word_valid, 1'b0);
        check("t6_rst_ferr", frame_err, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(60);
        check("t6_tail_pulses", vcnt - v0, 0);
        check("t6_tail_ferr", fcnt - f0, 0);
        send(8'h31, 1'b1);
        idle(5);
        check("t6_next_pulses", vcnt - v0, 1);
        check("t6_next_word", word_out, 8'h31);

        check("both_strobes", both_cnt, 0);
        check("wide_strobes", wide_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
